// File: rtl/dcp_arb_unit.sv
// -----------------------------------------------------------------------------
// dcp_arb_unit
//   Round-robin N:1 beat arbiter with a registered output stage. It can
//   optionally lock onto one requester from the first beat of a packet until
//   that packet's last beat.
//
//   Build option:
//     DCP_ARB_PKT_LOCK_EN  defined   -> packet lock (IDLE/LOCK FSM active)
//                          undefined -> every beat arbitrates on its own;
//                                       iLast is only forwarded to oLast
//
//   Handshake (every port pair below):
//     A beat moves when valid and ready are both high at a rising edge.
//     Ready never depends on the same requester's payload. Valid must not
//     wait for ready.
//
//   Ports:
//     iClk, iRst     clock, synchronous active-high reset
//     iVld/oRdy      per-requester beat handshake (NUM bits each)
//     iPld/iDst      requester k payload/destination at [k*DW +: DW] / [k*AW +: AW]
//     iLast          per-requester last-beat-of-packet flag
//     oVld/iRdy      merged output handshake
//     oPld/oDst/oLast registered merged beat
//     oGnt           index of the requester whose beat sits in the output register
//     oDbgLock       FSM state (1 = LOCK)
//     oDbgPtr        round-robin search start pointer
// -----------------------------------------------------------------------------
module dcp_arb_unit #(
    parameter int DW  = 16,
    parameter int AW  = 4,
    parameter int NUM = 4
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic [NUM-1:0]         iVld,
    output logic [NUM-1:0]         oRdy,
    input  logic [NUM*DW-1:0]      iPld,
    input  logic [NUM*AW-1:0]      iDst,
    input  logic [NUM-1:0]         iLast,
    output logic                   oVld,
    input  logic                   iRdy,
    output logic [DW-1:0]          oPld,
    output logic [AW-1:0]          oDst,
    output logic                   oLast,
    output logic [$clog2(NUM)-1:0] oGnt,
    output logic                   oDbgLock,
    output logic [$clog2(NUM)-1:0] oDbgPtr
);

    localparam int GW = $clog2(NUM);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t        state, stateNext;
    logic [GW-1:0] ptr, ptrNext;
    logic [GW-1:0] owner, ownerNext;
    logic [GW-1:0] scanWin, winner;
    logic          scanHit, winVld, winLast;
    logic          ld, xfer;

    // Cyclic first-valid search starting at ptr. NUM is a power of two, so
    // the GW-bit add wraps modulo NUM.
    always_comb begin
        scanHit = 1'b0;
        scanWin = ptr;
        for (int i = 0; i < NUM; i++) begin
            if (!scanHit && iVld[GW'(ptr + GW'(i))]) begin
                scanHit = 1'b1;
                scanWin = GW'(ptr + GW'(i));
            end
        end
    end

    // While locked, the owner is the only candidate, even when it is not
    // valid. That stalls the port rather than letting another packet cut in.
    always_comb begin
        winner = scanWin;
        winVld = scanHit;
`ifdef DCP_ARB_PKT_LOCK_EN
        if (state == LOCK) begin
            winner = owner;
            winVld = iVld[owner];
        end
`endif
    end

    assign ld      = !oVld || iRdy;
    assign xfer    = ld && winVld && !iRst;
    assign winLast = iLast[winner];
    assign oRdy    = xfer ? (NUM'(1) << winner) : '0;

    // FSM next-state / pointer / owner
    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        ownerNext = owner;
`ifdef DCP_ARB_PKT_LOCK_EN
        case (state)
            IDLE: begin
                if (xfer && !winLast) begin
                    stateNext = LOCK;
                    ownerNext = winner;
                end
            end
            LOCK: begin
                if (xfer && winLast) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        // Fairness advances per packet: only a completed packet moves ptr.
        if (xfer && winLast) begin
            ptrNext = winner + 1'b1;
        end
`else
        stateNext = IDLE;
        if (xfer) begin
            ptrNext = winner + 1'b1;
        end
`endif
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
            owner <= ownerNext;
        end
    end

    // Output register. The beat fields change only when a beat is loaded.
    // A load slot with no winner just empties the stage.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oVld  <= 1'b0;
            oPld  <= '0;
            oDst  <= '0;
            oLast <= 1'b0;
            oGnt  <= '0;
        end else if (ld) begin
            oVld <= xfer;
            if (xfer) begin
                oPld  <= iPld[winner*DW +: DW];
                oDst  <= iDst[winner*AW +: AW];
                oLast <= winLast;
                oGnt  <= winner;
            end
        end
    end

    assign oDbgLock = (state == LOCK);
    assign oDbgPtr  = ptr;

endmodule

// File: tb/tb_dcp_arb_unit.sv
// -----------------------------------------------------------------------------
// tb_dcp_arb_unit
//   Directed bench for dcp_arb_unit (NUM=4, DW=16, AW=4). Each requester
//   sends numbered beats. Payload = base[k] + serial, dst = serial + k.
//   Each test pushes the beat order it expects into exp_q. Every output
//   beat taken downstream is popped and compared.
//   Expectations follow DCP_ARB_PKT_LOCK_EN, so the same file serves both builds.
// -----------------------------------------------------------------------------
module tb_dcp_arb_unit;

    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int NUM = 4;
    localparam int GW  = 2;
    localparam int W   = GW + 1 + AW + DW;

    logic              iClk = 1'b0;
    logic              iRst;
    logic [NUM-1:0]    iVld;
    logic [NUM-1:0]    oRdy;
    logic [NUM*DW-1:0] iPld;
    logic [NUM*AW-1:0] iDst;
    logic [NUM-1:0]    iLast;
    logic              oVld;
    logic              iRdy;
    logic [DW-1:0]     oPld;
    logic [AW-1:0]     oDst;
    logic              oLast;
    logic [GW-1:0]     oGnt;
    logic              oDbgLock;
    logic [GW-1:0]     oDbgPtr;

    dcp_arb_unit #(.DW(DW), .AW(AW), .NUM(NUM)) dut (
        .iClk(iClk), .iRst(iRst), .iVld(iVld), .oRdy(oRdy), .iPld(iPld),
        .iDst(iDst), .iLast(iLast), .oVld(oVld), .iRdy(iRdy), .oPld(oPld),
        .oDst(oDst), .oLast(oLast), .oGnt(oGnt), .oDbgLock(oDbgLock),
        .oDbgPtr(oDbgPtr)
    );

    // ---------------- clock / watchdog ----------------
    always #5 iClk = ~iClk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    int pkts[NUM];       // packets still to send
    int len[NUM];        // beats per packet
    int bip[NUM];        // beat index within current packet
    int serial[NUM];     // beats accepted so far (driver side)
    int expSerial[NUM];  // beats already predicted (scoreboard side)
    int base[NUM];       // payload base
    bit hold[NUM];       // force iVld low

    logic [NUM-1:0] lastRdy;
    logic           lastVld;
    logic [DW-1:0]  lastPld;
    logic [GW-1:0]  lastGnt;
    logic           lastLock;
    logic [GW-1:0]  lastPtr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive();
        for (int k = 0; k < NUM; k++) begin
            iVld[k]            = (pkts[k] > 0) && !hold[k];
            iPld[k*DW +: DW]   = DW'(base[k] + serial[k]);
            iDst[k*AW +: AW]   = AW'(serial[k] + k);
            iLast[k]           = (bip[k] == len[k] - 1);
        end
    endtask

    task automatic expBeat(input int k, input bit last);
        logic [W-1:0] e;
        e = {GW'(k), last, AW'(expSerial[k] + k), DW'(base[k] + expSerial[k])};
        exp_q.push_back(e);
        expSerial[k]++;
    endtask

    // One clock: sample and check at negedge, then advance sources after posedge.
    task automatic cycle();
        logic [NUM-1:0] acc;
        logic [W-1:0]   e;
        @(negedge iClk);
        lastRdy  = oRdy;
        lastVld  = oVld;
        lastPld  = oPld;
        lastGnt  = oGnt;
        lastLock = oDbgLock;
        lastPtr  = oDbgPtr;
        acc      = oRdy & iVld;
        chk("rdy_onehot0", 32'($onehot0(oRdy)), 32'd1);
        chk("rdy_without_vld", 32'(oRdy & ~iVld), 32'd0);
        if (!iRst && oVld && iRdy) begin
            if (exp_q.size() == 0) begin
                chk("beat_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("beat", 32'({oGnt, oLast, oDst, oPld}), 32'(e));
            end
        end
        @(posedge iClk);
        #1;
        for (int k = 0; k < NUM; k++) begin
            if (acc[k]) begin
                serial[k]++;
                if (bip[k] == len[k] - 1) begin
                    bip[k] = 0;
                    pkts[k]--;
                end else begin
                    bip[k]++;
                end
            end
        end
        drive();
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        iRst  = 1'b1;
        iRdy  = 1'b1;
        iVld  = '1;
        iPld  = '1;
        iDst  = '1;
        iLast = '1;
        for (int k = 0; k < NUM; k++) begin
            pkts[k] = 0; len[k] = 1; bip[k] = 0; serial[k] = 0;
            expSerial[k] = 0; base[k] = k << 12; hold[k] = 1'b0;
        end

        // Reset state, with every requester valid.
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        chk("rst_oRdy", 32'(oRdy), 32'd0);
        chk("rst_oVld", 32'(oVld), 32'd0);
        chk("rst_oPld", 32'(oPld), 32'd0);
        chk("rst_oDst_oLast_oGnt", 32'({oDst, oLast, oGnt}), 32'd0);
        chk("rst_state", 32'(oDbgLock), 32'd0);
        chk("rst_ptr", 32'(oDbgPtr), 32'd0);
        @(posedge iClk);
        #1;
        iRst = 1'b0;

        // All requesters valid with single-beat packets: grants 0,1,2,3,0,1,2,3.
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NUM; k++) expBeat(k, 1'b1);
        for (int k = 0; k < NUM; k++) begin pkts[k] = 2; len[k] = 1; end
        drive();
        cycle();
        chk("rr_first_rdy", 32'(lastRdy), 32'h1);
        chk("rr_first_vld", 32'(lastVld), 32'd0);
        for (int c = 0; c < 8; c++) begin
            cycle();
            chk("rr_vld_streaming", 32'(lastVld), 32'd1);
        end
        chk("rr_q_empty", 32'(exp_q.size()), 32'd0);

        // Requester 1 sends a 3-beat packet while requester 2 has two single beats.
        pkts[1] = 1; len[1] = 3;
        pkts[2] = 2; len[2] = 1;
`ifdef DCP_ARB_PKT_LOCK_EN
        expBeat(1, 0); expBeat(1, 0); expBeat(1, 1); expBeat(2, 1); expBeat(2, 1);
`else
        expBeat(1, 0); expBeat(2, 1); expBeat(1, 0); expBeat(2, 1); expBeat(1, 1);
`endif
        drive();
        cycle();
        chk("pkt_rdy_c1", 32'(lastRdy), 32'h2);
        cycle();
`ifdef DCP_ARB_PKT_LOCK_EN
        chk("pkt_rdy_c2", 32'(lastRdy), 32'h2);
`else
        chk("pkt_rdy_c2", 32'(lastRdy), 32'h4);
`endif
        waitDrain(20);
`ifdef DCP_ARB_PKT_LOCK_EN
        chk("pkt_ptr", 32'(oDbgPtr), 32'd3);
`else
        chk("pkt_ptr", 32'(oDbgPtr), 32'd2);
`endif

        // Owner (3) drops valid for 2 cycles mid-packet; requester 0 is waiting.
        pkts[3] = 1; len[3] = 3;
        pkts[0] = 1; len[0] = 1;
`ifdef DCP_ARB_PKT_LOCK_EN
        expBeat(3, 0); expBeat(3, 0); expBeat(3, 1); expBeat(0, 1);
`else
        expBeat(3, 0); expBeat(0, 1); expBeat(3, 0); expBeat(3, 1);
`endif
        drive();
        cycle();
        chk("gap_rdy_c1", 32'(lastRdy), 32'h8);
        hold[3] = 1'b1;
        drive();
        cycle();
`ifdef DCP_ARB_PKT_LOCK_EN
        chk("gap_rdy_h1", 32'(lastRdy), 32'h0);
        chk("gap_locked", 32'(lastLock), 32'd1);
`else
        chk("gap_rdy_h1", 32'(lastRdy), 32'h1);
`endif
        cycle();
        chk("gap_rdy_h2", 32'(lastRdy), 32'h0);
        hold[3] = 1'b0;
        drive();
        waitDrain(20);
`ifdef DCP_ARB_PKT_LOCK_EN
        chk("gap_ptr", 32'(oDbgPtr), 32'd1);
`else
        chk("gap_ptr", 32'(oDbgPtr), 32'd0);
`endif

        // Downstream stall: A5A5 beat held 3 cycles, then drain and load together.
        base[2] = 32'hA5A5 - serial[2];
        pkts[2] = 1; len[2] = 1;
        expBeat(2, 1);
        iRdy = 1'b0;
        drive();
        cycle();
        chk("stall_load_rdy", 32'(lastRdy), 32'h4);
        pkts[1] = 1; len[1] = 1;
        expBeat(1, 1);
        drive();
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("stall_rdy", 32'(lastRdy), 32'h0);
            chk("stall_vld", 32'(lastVld), 32'd1);
            chk("stall_pld", 32'(lastPld), 32'hA5A5);
            chk("stall_gnt", 32'(lastGnt), 32'd2);
        end
        iRdy = 1'b1;
        drive();
        cycle();
        chk("stall_release_rdy", 32'(lastRdy), 32'h2);
        waitDrain(10);

        // Reset during the second beat of a 4-beat packet from requester 1.
        pkts[1] = 1; len[1] = 4;
        expBeat(1, 0);
        drive();
        cycle();
        chk("rstmid_rdy_c1", 32'(lastRdy), 32'h2);
        iRst = 1'b1;
        drive();
        cycle();
        chk("rstmid_rdy_in_reset", 32'(lastRdy), 32'h0);
        iRst = 1'b0;
        pkts[1] = 0; bip[1] = 0;
        exp_q.delete();
        for (int k = 0; k < NUM; k++) expSerial[k] = serial[k];
        pkts[3] = 1; len[3] = 1;
        expBeat(3, 1);
        drive();
        cycle();
        chk("rstmid_vld", 32'(lastVld), 32'd0);
        chk("rstmid_state", 32'(lastLock), 32'd0);
        chk("rstmid_ptr", 32'(lastPtr), 32'd0);
        chk("rstmid_rdy_r3", 32'(lastRdy), 32'h8);
        waitDrain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcp_arb_unit.md
DCP_ARB_UNIT -- requirements
Module: dcp_arb_unit

Interface
REQ-001 Parameter DW, default 16, payload width per beat.
REQ-002 Parameter AW, default 4, destination field width per beat.
REQ-003 Parameter NUM, default 4, number of requesters, a power of two and at least 2; GW = $clog2(NUM).
REQ-004 Port iClk  input  1  single clock, all logic on rising edge.
REQ-005 Port iRst  input  1  synchronous, active-high reset.
REQ-006 Port iVld  input  NUM  per-requester beat valid.
REQ-007 Port oRdy  output  NUM  per-requester beat accepted.
REQ-008 Port iPld  input  NUM*DW  requester k payload in bits [k*DW +: DW].
REQ-009 Port iDst  input  NUM*AW  requester k destination in bits [k*AW +: AW].
REQ-010 Port iLast  input  NUM  per-requester last beat of packet.
REQ-011 Port oVld  output  1  merged output valid, registered.
REQ-012 Port iRdy  input  1  downstream ready.
REQ-013 Port oPld  output  DW  merged payload, registered.
REQ-014 Port oDst  output  AW  merged destination, registered.
REQ-015 Port oLast  output  1  merged last flag, registered.
REQ-016 Port oGnt  output  GW  index of the requester whose beat is in the output register.

Function
REQ-017 Output register load enable: ld = !oVld || iRdy; beat transfer on requester k when iVld[k] && oRdy[k].
REQ-018 oRdy SHALL be one-hot or zero, asserted only for the current winner and only when ld=1; oRdy[k] SHALL never assert while iVld[k]=0.
REQ-019 Latency SHALL be 1 cycle: a beat accepted in cycle t appears on oVld/oPld/oDst/oLast/oGnt in t+1.
REQ-020 Throughput SHALL be one beat per cycle while iRdy=1; load and drain in the same cycle SHALL be supported.
REQ-021 If iRdy=0 and oVld=1, output register contents SHALL hold unchanged and all oRdy SHALL be 0.
REQ-022 FSM states IDLE and LOCK; in IDLE the winner is the first requester with iVld=1, searching cyclically from pointer ptr (GW bits).
REQ-023 IDLE -> LOCK when the winner's beat transfers with iLast=0; owner register stores winner index.
REQ-024 In LOCK only the owner may win, even if owner iVld=0; other requesters see oRdy=0.
REQ-025 LOCK -> IDLE when the owner's beat with iLast=1 transfers.
REQ-026 A single-beat packet (iLast=1 on first beat) SHALL transfer without leaving IDLE.
REQ-027 ptr SHALL update to (winner+1) mod NUM on every transfer of a beat with iLast=1; wrap from NUM-1 to 0 is modular.
REQ-028 No requests in IDLE: no transfer, ptr and state unchanged, oVld drains normally.
REQ-029 oPld/oDst/oLast/oGnt SHALL only change on a load; payload passes unmodified.

Reset
REQ-030 While iRst=1 at a clock edge: state IDLE, ptr=0, owner=0, oVld=0, oPld=0, oDst=0, oLast=0, oGnt=0; oRdy SHALL be 0 while iRst=1.
REQ-031 Reset mid-packet SHALL drop the lock and any beat in the output register; no partial recovery.

Configuration
REQ-032 Macro DCP_ARB_PKT_LOCK_EN defined: packet lock per REQ-023..REQ-025.
REQ-033 Macro DCP_ARB_PKT_LOCK_EN undefined: FSM stays in IDLE, every beat arbitrates independently, ptr updates to (winner+1) mod NUM on every transfer regardless of iLast; iLast passes to oLast only.

Verification
REQ-034 NUM=4, iVld=4'b1111, all iLast=1, iRdy=1 after reset -> oGnt sequence 0,1,2,3,0 on consecutive cycles, oVld=1 from cycle 2.
REQ-035 Lock on: requester 1 sends 3-beat packet (last on beat 3) while requester 2 valid -> three beats from 1 contiguous, then requester 2; oRdy[2]=0 during lock.
REQ-036 Lock on: owner drops iVld mid-packet for 2 cycles, requester 0 valid -> no transfer for 2 cycles, oRdy[0]=0, packet resumes from owner.
REQ-037 iRdy=0 for 3 cycles with oVld=1, oPld=16'hA5A5 -> output held, oRdy=0; iRdy=1 -> drain and new load same cycle.
REQ-038 iRst=1 in cycle 2 of a 4-beat packet -> next cycle oVld=0, state IDLE, ptr=0; requester 3 then wins immediately if only it is valid.
REQ-039 Lock off, same stimulus as REQ-035 -> beats from requesters 1 and 2 interleave 1,2,1,2,1.
